// File: rtl/array_access_sched_pkg.sv
// Shared types and helpers for the array access scheduler: op codes, FSM states,
// the latched cell index and the reset-time cell contents.
package array_sched_pkg;

    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ADD   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] plane;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } idx_t;

    function automatic int unsigned init_value(input int unsigned p, input int unsigned r,
                                               input int unsigned c, input int unsigned nrow,
                                               input int unsigned ncol);
        return p * nrow * ncol + r * ncol + c;
    endfunction

endpackage

// File: rtl/array_access_sched_rr_arbiter2.sv
// Two-input round-robin arbiter: one-hot grant; on contention the requester
// not granted most recently wins. Priority favours requester 0 after reset.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic prio;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/array_access_sched.sv
// Arbiter/sequencer for a shared NPLANE x NROW x NCOL word array: read, write
// and locked two-cycle add for two requesters, one response pulse per request.
module array_access_sched
    import array_sched_pkg::*;
#(
    parameter  int NPLANE = 3,
    parameter  int NROW   = 2,
    parameter  int NCOL   = 4,
    parameter  int W      = 16,
    localparam int PW     = $clog2(NPLANE),
    localparam int RW     = $clog2(NROW),
    localparam int CW     = $clog2(NCOL)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID [2],
    output logic          REQ_READY [2],
    input  logic [1:0]    REQ_OP    [2],
    input  logic [PW-1:0] REQ_PLANE [2],
    input  logic [RW-1:0] REQ_ROW   [2],
    input  logic [CW-1:0] REQ_COL   [2],
    input  logic [W-1:0]  REQ_DATA  [2],
    output logic          RSP_VALID [2],
    output logic [W-1:0]  RSP_DATA  [2],
    output logic          RSP_ERR   [2],
    output logic          BUSY
);

    localparam int DEPTH = NPLANE * NROW * NCOL;
    localparam int AW    = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];

    state_t        state, state_nxt;
    logic [1:0]    req_vec;
    logic [1:0]    grant;
    logic          accept;
    logic          gsel;

    op_e           sel_op;
    logic [PW-1:0] sel_plane;
    logic [RW-1:0] sel_row;
    logic [CW-1:0] sel_col;
    logic [W-1:0]  sel_data;
    logic          sel_err;
    logic [AW-1:0] sel_addr;
    logic [W-1:0]  sel_cell;

    idx_t          rmw_idx;
    logic          rmw_who;
    logic [W-1:0]  rmw_old;
    logic [W-1:0]  rmw_addend;
    logic [AW-1:0] rmw_addr;
    logic [W-1:0]  rmw_sum;

    // Arbitration only runs while idle and out of reset, so READY is gated too.
    assign req_vec = (state == ST_IDLE && !RST) ? {REQ_VALID[1], REQ_VALID[0]} : 2'b00;

    rr_arbiter2 u_arb (
        .clk    (CLK),
        .rst    (RST),
        .req    (req_vec),
        .accept (accept),
        .grant  (grant)
    );

    assign REQ_READY[0] = grant[0];
    assign REQ_READY[1] = grant[1];
    assign BUSY         = (state == ST_RMW);

    always_comb begin
        gsel      = grant[1];
        sel_op    = op_e'(REQ_OP[gsel]);
        sel_plane = REQ_PLANE[gsel];
        sel_row   = REQ_ROW[gsel];
        sel_col   = REQ_COL[gsel];
        sel_data  = REQ_DATA[gsel];
        sel_err   = (sel_op == OP_RSVD) || (int'(sel_plane) >= NPLANE) ||
                    (int'(sel_row) >= NROW) || (int'(sel_col) >= NCOL);
        sel_addr  = AW'(int'(sel_plane) * NROW * NCOL + int'(sel_row) * NCOL + int'(sel_col));
        sel_cell  = '0;
        if (!sel_err) begin
            sel_cell = mem[sel_addr];
        end
        rmw_addr  = AW'(int'(rmw_idx.plane) * NROW * NCOL + int'(rmw_idx.row) * NCOL +
                        int'(rmw_idx.col));
        rmw_sum   = rmw_old + rmw_addend;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    accept = 1'b1;
                    if (!sel_err && sel_op == OP_ADD) begin
                        state_nxt = ST_RMW;
                    end
                end
            end
            ST_RMW:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset has priority over the RMW write, so an add interrupted by RST is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned p = 0; p < NPLANE; p++) begin
                for (int unsigned r = 0; r < NROW; r++) begin
                    for (int unsigned c = 0; c < NCOL; c++) begin
                        mem[AW'(init_value(p, r, c, NROW, NCOL))] <=
                            W'(init_value(p, r, c, NROW, NCOL));
                    end
                end
            end
            for (int unsigned i = 0; i < 2; i++) begin
                RSP_VALID[i] <= 1'b0;
                RSP_DATA[i]  <= '0;
                RSP_ERR[i]   <= 1'b0;
            end
            rmw_idx    <= '0;
            rmw_who    <= 1'b0;
            rmw_old    <= '0;
            rmw_addend <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                RSP_VALID[i] <= 1'b0;
                RSP_ERR[i]   <= 1'b0;
            end
            if (accept) begin
                if (sel_err) begin
                    RSP_VALID[gsel] <= 1'b1;
                    RSP_DATA[gsel]  <= '0;
                    RSP_ERR[gsel]   <= 1'b1;
                end else begin
                    case (sel_op)
                        OP_READ: begin
                            RSP_VALID[gsel] <= 1'b1;
                            RSP_DATA[gsel]  <= sel_cell;
                        end
                        OP_WRITE: begin
                            mem[sel_addr]   <= sel_data;
                            RSP_VALID[gsel] <= 1'b1;
                            RSP_DATA[gsel]  <= sel_cell;
                        end
                        OP_ADD: begin
                            rmw_idx.plane <= IDX_W'(sel_plane);
                            rmw_idx.row   <= IDX_W'(sel_row);
                            rmw_idx.col   <= IDX_W'(sel_col);
                            rmw_who       <= gsel;
                            rmw_old       <= sel_cell;
                            rmw_addend    <= sel_data;
                        end
                        default: ;
                    endcase
                end
            end
            if (state == ST_RMW) begin
                mem[rmw_addr]      <= rmw_sum;
                RSP_VALID[rmw_who] <= 1'b1;
                RSP_DATA[rmw_who]  <= rmw_sum;
            end
        end
    end

endmodule

// File: tb/tb_array_access_sched.sv
// Directed and random checks of array_access_sched against a cycle-level
// behavioural model of grant order, storage contents and responses.
module tb_array_access_sched;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [1:0]  req_op    [2];
    logic [1:0]  req_plane [2];
    logic [0:0]  req_row   [2];
    logic [1:0]  req_col   [2];
    logic [15:0] req_data  [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_data  [2];
    logic        rsp_err   [2];
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int rsp_cnt = 0;

    // Reference state
    int m_mem [24];
    int m_prio;
    bit m_busy;
    int m_who;
    int m_addr;
    int m_sum;

    array_access_sched #(
        .NPLANE (3),
        .NROW   (2),
        .NCOL   (4),
        .W      (16)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_OP    (req_op),
        .REQ_PLANE (req_plane),
        .REQ_ROW   (req_row),
        .REQ_COL   (req_col),
        .REQ_DATA  (req_data),
        .RSP_VALID (rsp_valid),
        .RSP_DATA  (rsp_data),
        .RSP_ERR   (rsp_err),
        .BUSY      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i, input bit v, input int op, input int p, input int r,
                         input int c, input int d);
        req_valid[i] = v;
        req_op[i]    = 2'(op);
        req_plane[i] = 2'(p);
        req_row[i]   = 1'(r);
        req_col[i]   = 2'(c);
        req_data[i]  = 16'(d);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 24; k++) m_mem[k] = k;
        m_prio = 0;
        m_busy = 1'b0;
    endtask

    // One clock: check READY/BUSY mid-cycle, advance the model, check responses.
    task automatic tick();
        bit [1:0] gnt;
        bit       ev [2];
        int       ed [2];
        bit       ee [2];
        bit       was_rst;
        int       g, op, p, r, c, d, a;
        ev = '{1'b0, 1'b0};
        ed = '{0, 0};
        ee = '{1'b0, 1'b0};
        @(negedge clk);
        gnt = 2'b00;
        if (!rst && !m_busy) begin
            if (req_valid[0] && req_valid[1]) gnt = (m_prio == 1) ? 2'b10 : 2'b01;
            else gnt = {req_valid[1], req_valid[0]};
        end
        chk("ready0", 32'(req_ready[0]), 32'(gnt[0]));
        chk("ready1", 32'(req_ready[1]), 32'(gnt[1]));
        chk("busy", 32'(busy), 32'(m_busy));
        was_rst = rst;
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            m_mem[m_addr] = m_sum;
            ev[m_who] = 1'b1;
            ed[m_who] = m_sum;
            m_busy = 1'b0;
        end else if (gnt != 2'b00) begin
            g  = gnt[1] ? 1 : 0;
            m_prio = (g == 0) ? 1 : 0;
            op = int'(req_op[g]);
            p  = int'(req_plane[g]);
            r  = int'(req_row[g]);
            c  = int'(req_col[g]);
            d  = int'(req_data[g]);
            ev[g] = 1'b1;
            if (op == 3 || p >= 3 || r >= 2 || c >= 4) begin
                ee[g] = 1'b1;
                ed[g] = 0;
            end else begin
                a = p * 8 + r * 4 + c;
                case (op)
                    0: ed[g] = m_mem[a];
                    1: begin ed[g] = m_mem[a]; m_mem[a] = d; end
                    default: begin
                        ev[g]  = 1'b0;
                        m_busy = 1'b1;
                        m_who  = g;
                        m_addr = a;
                        m_sum  = (m_mem[a] + d) % 65536;
                    end
                endcase
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i] === 1'b1) rsp_cnt++;
            chk($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]), 32'(ev[i]));
            if (ev[i] || was_rst) begin
                chk($sformatf("rsp_data%0d", i), 32'(rsp_data[i]), 32'(ed[i]));
                chk($sformatf("rsp_err%0d", i), 32'(rsp_err[i]), 32'(ee[i]));
            end
        end
    endtask

    initial begin
        int cnt0;
        drive(0, 1'b0, 0, 0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0, 0, 0);
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Read (1,0,1)
        drive(0, 1'b1, 0, 1, 0, 1, 0);
        tick();
        chk("read_101", 32'(rsp_data[0]), 32'd9);
        drive(0, 1'b0, 0, 0, 0, 0, 0);

        // Write then read back (2,1,2)
        drive(1, 1'b1, 1, 2, 1, 2, 16'hABCD);
        tick();
        chk("write_old", 32'(rsp_data[1]), 32'd22);
        drive(1, 1'b1, 0, 2, 1, 2, 0);
        tick();
        chk("write_rb", 32'(rsp_data[1]), 32'hABCD);
        drive(1, 1'b0, 0, 0, 0, 0, 0);

        // Wrapping add on (0,0,3)
        drive(0, 1'b1, 2, 0, 0, 3, 16'hFFFF);
        tick();
        drive(0, 1'b0, 0, 0, 0, 0, 0);
        tick();
        chk("add_valid", 32'(rsp_valid[0]), 32'd1);
        chk("add_sum", 32'(rsp_data[0]), 32'h0002);
        drive(0, 1'b1, 0, 0, 0, 3, 0);
        tick();
        chk("add_rb", 32'(rsp_data[0]), 32'h0002);

        // Both requesters contend with reads
        cnt0 = rsp_cnt;
        drive(0, 1'b1, 0, 0, 1, 1, 0);
        drive(1, 1'b1, 0, 2, 0, 2, 0);
        for (int k = 0; k < 8; k++) tick();
        chk("pair_count", 32'(rsp_cnt - cnt0), 32'd8);
        drive(0, 1'b0, 0, 0, 0, 0, 0);

        // Error requests
        drive(1, 1'b1, 0, 3, 0, 0, 0);
        tick();
        chk("err_plane", 32'(rsp_err[1]), 32'd1);
        drive(1, 1'b1, 3, 1, 1, 1, 16'h1234);
        tick();
        chk("err_op", 32'(rsp_err[1]), 32'd1);
        drive(1, 1'b1, 0, 1, 1, 1, 0);
        tick();
        chk("err_nochg", 32'(rsp_data[1]), 32'd13);
        drive(1, 1'b0, 0, 0, 0, 0, 0);

        // Add abandoned by reset during RMW
        drive(0, 1'b1, 2, 0, 0, 0, 16'h0005);
        tick();
        drive(0, 1'b0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 0, 0, 0, 0, 0);
        tick();
        chk("rst_abandon", 32'(rsp_data[0]), 32'd0);
        drive(0, 1'b0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
            end
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        drive(0, 1'b0, 0, 0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/array_access_sched.md
# array_access_sched

Arbiter and sequencer for a shared 3-D register array of NPLANE x NROW x NCOL words of W bits, the storage shape used by the team's array entities. Two requesters issue read, write, or add (read-modify-write) operations through valid/ready handshakes. The block grants them round-robin, runs the add as a two-cycle locked operation, and returns one response pulse per accepted request. It sits between the datapath front-ends and the coefficient/state array they share.

## Interface
Parameters:
- NPLANE, 3, number of planes (outer dimension)
- NROW, 2, rows per plane
- NCOL, 4, columns per row
- W, 16, word width

Index widths are PW=$clog2(NPLANE), RW=$clog2(NROW), CW=$clog2(NCOL).

Ports (per-requester ports are unpacked arrays [2]):
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous and active-high
- REQ_VALID  in  1 [2]  request present
- REQ_READY  out  1 [2]  request accepted this cycle when VALID is also high
- REQ_OP  in  2 [2]  00 read, 01 write, 10 add, 11 reserved
- REQ_PLANE  in  PW [2]  plane index
- REQ_ROW  in  RW [2]  row index
- REQ_COL  in  CW [2]  column index
- REQ_DATA  in  W [2]  write data / addend
- RSP_VALID  out  1 [2]  one-cycle response pulse
- RSP_DATA  out  W [2]  response word
- RSP_ERR  out  1 [2]  response is an error
- BUSY  out  1  add operation in progress

## Operation
- Storage is NPLANE*NROW*NCOL words. At reset, cell (p,r,c) loads p*NROW*NCOL + r*NCOL + c; with the defaults this gives 0..23.
- State machine has two states:
  - IDLE: may accept a request.
  - RMW: finishes an add.
  - IDLE->RMW on accepting a valid add. RMW->IDLE unconditionally after one cycle.
- Grant (IDLE only):
  - If exactly one REQ_VALID is high, that requester is granted.
  - If both are high, the requester not granted most recently wins.
  - The priority pointer favours requester 0 after reset.
  - REQ_READY[i] = (state==IDLE) && grant==i, so at most one READY is high per cycle.
  - REQ_READY is 0 in RMW and during RST.
- Read: RSP_DATA = cell.
- Write: cell <= REQ_DATA; RSP_DATA = previous cell value.
- Add:
  - Acceptance cycle latches the operand and the current cell value.
  - The RMW cycle writes (old + addend) mod 2^W.
  - RSP_DATA = the new sum.
- Error: REQ_OP==11, or REQ_PLANE>=NPLANE, or REQ_COL>=NCOL, or REQ_ROW>=NROW.
  - Request is accepted normally; no storage change; no RMW.
  - RSP_ERR=1, RSP_DATA=0.
- Responses carry no backpressure. RSP_VALID is asserted for exactly one cycle, only to the accepting requester.
- The priority pointer updates on every accepted request, including errors.

## Timing
- Reset values: REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, BUSY=0, state IDLE, pointer=0, array reinitialised.
- Read, write and error requests:
  - Accepted at edge T; RSP_VALID at cycle T+1.
  - A new request may be accepted at T+1, giving back-to-back throughput of 1 per cycle.
- Add:
  - Accepted at T. BUSY=1 during cycle T+1, and the cell is written at the end of T+1.
  - RSP_VALID at T+2. The next acceptance is possible at T+2.
- A read accepted the cycle after a write or add completes on the same cell returns the updated value; no stale data.
- The other requester holding VALID during RMW stalls and is granted at T+2, because it did not win last.
- RST asserted during RMW abandons the add: no write and no response. The array reinitialises and all outputs take reset values on the next edge.

## Structure
- Package array_sched_pkg holds:
  - the op enum (OP_READ, OP_WRITE, OP_ADD, OP_RSVD)
  - the FSM state enum
  - a packed index struct {plane, row, col}
  - an init_value(p,r,c) function used for the reset load
- Sub-module rr_arbiter2: two-input round-robin grant with a last-grant pointer, an update-on-accept input, and a one-hot grant output.
- The top level holds storage, the FSM, and the response registers.

## Test plan
- After reset, requester 0 reads (1,0,1) -> RSP_VALID[0] one cycle later, RSP_DATA=9, RSP_ERR=0.
- Requester 1 writes 0xABCD to (2,1,2) -> RSP_DATA=22 (old value). A read of (2,1,2) on the next cycle -> 0xABCD.
- Requester 0 adds 0xFFFF to (0,0,3):
  - BUSY=1 for one cycle.
  - RSP at T+2 with RSP_DATA=0x0002 (wrap).
  - A following read returns 0x0002.
- Both requesters hold VALID with reads for 4 requests each -> grants alternate 0,1,0,1,…; each RSP goes only to its requester; 8 responses total.
- Requester 1 reads plane 3 -> RSP_ERR=1, RSP_DATA=0, storage unchanged. An op=11 request also errors.
- Start an add on (0,0,0) and assert RST during the RMW cycle -> no RSP_VALID; after reset, a read of (0,0,0) returns 0.
